// File: rtl/fft_frame_sched_if.sv
// Bundle of the sample source, load-port, FFT-core and output-stream signals
// around the frame scheduler. The master modport is the scheduler itself,
// the slave modport is the surrounding environment (source, memory, core, sink).
// Handshake: a sample moves when in_valid and in_ready are both high on a rising
// clock edge; out_valid/ld_wr_en/fft_out_en are qualifiers with no backpressure.
interface fft_frame_sched_if #(
  parameter int bit_width = 29,
  parameter int SIZE      = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [bit_width-1:0] in_re;
  logic [bit_width-1:0] in_im;
  logic                 ld_wr_en;
  logic [SIZE:0]        ld_wr_addr;
  logic [bit_width-1:0] ld_re;
  logic [bit_width-1:0] ld_im;
  logic                 mem_sel;
  logic                 fft_start;
  logic                 fft_out_en;
  logic [bit_width-1:0] fft_re;
  logic [bit_width-1:0] fft_im;
  logic                 out_valid;
  logic                 out_last;
  logic [bit_width-1:0] out_re;
  logic [bit_width-1:0] out_im;
  logic                 frame_done;
  logic [15:0]          frame_cnt;
  logic                 drop_err;
  logic                 tmo_err;
  logic [1:0]           dbg_state;

  modport master (
    input  in_valid, in_re, in_im, fft_out_en, fft_re, fft_im,
    output in_ready, ld_wr_en, ld_wr_addr, ld_re, ld_im, mem_sel, fft_start,
           out_valid, out_last, out_re, out_im, frame_done, frame_cnt,
           drop_err, tmo_err, dbg_state
  );

  modport slave (
    output in_valid, in_re, in_im, fft_out_en, fft_re, fft_im,
    input  in_ready, ld_wr_en, ld_wr_addr, ld_re, ld_im, mem_sel, fft_start,
           out_valid, out_last, out_re, out_im, frame_done, frame_cnt,
           drop_err, tmo_err, dbg_state
  );
endinterface

// File: rtl/fft_frame_sched.sv
// Frame scheduler for the in-place FFT core: LOAD N samples into the butterfly
// memory, pulse the core start, forward the N-beat result stream, then count
// the frame. A 16-bit watchdog aborts a RUN phase that never completes.
// Optional macro FFT_SCHED_BITREV_EN: load addresses are the bit-reversed
// sample index (decimation-in-time order); otherwise natural order.
// dbg_state exposes the FSM state: 0=LOAD 1=START 2=RUN 3=DONE.
module fft_frame_sched #(
  parameter int bit_width = 29,
  parameter int N         = 16,
  parameter int SIZE      = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  fft_frame_sched_if.master   bus
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [SIZE-1:0] LAST_IDX = SIZE'(N - 1);
  localparam logic [15:0]     WD_LIMIT = 16'(TIMEOUT - 1);

  state_t               state_q;
  logic                 in_ready_q;
  logic                 mem_sel_q;
  logic [SIZE-1:0]      load_cnt_q;
  logic [SIZE-1:0]      out_cnt_q;
  logic [15:0]          wd_q;
  logic                 ld_wr_en_q;
  logic [SIZE:0]        ld_wr_addr_q;
  logic [bit_width-1:0] ld_re_q;
  logic [bit_width-1:0] ld_im_q;
  logic                 fft_start_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic [bit_width-1:0] out_re_q;
  logic [bit_width-1:0] out_im_q;
  logic                 frame_done_q;
  logic [15:0]          frame_cnt_q;
  logic                 drop_err_q;
  logic                 tmo_err_q;

  // Memory address for the k-th sample of a frame; MSB is always 0.
  function automatic logic [SIZE:0] load_addr(input logic [SIZE-1:0] cnt);
    logic [SIZE:0] a;
    a = '0;
`ifdef FFT_SCHED_BITREV_EN
    for (int i = 0; i < SIZE; i++) begin
      a[i] = cnt[SIZE-1-i];
    end
`else
    a[SIZE-1:0] = cnt;
`endif
    return a;
  endfunction

  // Frame FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      in_ready_q   <= 1'b1;
      mem_sel_q    <= 1'b1;
      load_cnt_q   <= '0;
      out_cnt_q    <= '0;
      wd_q         <= '0;
      ld_wr_en_q   <= 1'b0;
      ld_wr_addr_q <= '0;
      ld_re_q      <= '0;
      ld_im_q      <= '0;
      fft_start_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_re_q     <= '0;
      out_im_q     <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      drop_err_q   <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      ld_wr_en_q   <= 1'b0;
      fft_start_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;

      // A sample offered while not ready is lost; remember it until reset.
      if (bus.in_valid && !in_ready_q) begin
        drop_err_q <= 1'b1;
      end

      case (state_q)
        S_LOAD: begin
          if (bus.in_valid && in_ready_q) begin
            ld_wr_en_q   <= 1'b1;
            ld_wr_addr_q <= load_addr(load_cnt_q);
            ld_re_q      <= bus.in_re;
            ld_im_q      <= bus.in_im;
            load_cnt_q   <= load_cnt_q + 1'b1;
            if (load_cnt_q == LAST_IDX) begin
              state_q    <= S_START;
              in_ready_q <= 1'b0;
            end
          end
        end

        S_START: begin
          // Last load write lands this cycle; hand the memory port to the core.
          state_q     <= S_RUN;
          fft_start_q <= 1'b1;
          mem_sel_q   <= 1'b0;
          wd_q        <= '0;
        end

        S_RUN: begin
          if (bus.fft_out_en) begin
            out_valid_q <= 1'b1;
            out_re_q    <= bus.fft_re;
            out_im_q    <= bus.fft_im;
            out_last_q  <= (out_cnt_q == LAST_IDX);
            out_cnt_q   <= out_cnt_q + 1'b1;
          end
          // The final beat wins over a watchdog expiry in the same cycle.
          if (bus.fft_out_en && (out_cnt_q == LAST_IDX)) begin
            state_q <= S_DONE;
          end else if (wd_q == WD_LIMIT) begin
            state_q    <= S_LOAD;
            tmo_err_q  <= 1'b1;
            load_cnt_q <= '0;
            out_cnt_q  <= '0;
            wd_q       <= '0;
            mem_sel_q  <= 1'b1;
            in_ready_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        S_DONE: begin
          state_q      <= S_LOAD;
          frame_done_q <= 1'b1;
          frame_cnt_q  <= frame_cnt_q + 1'b1;
          load_cnt_q   <= '0;
          out_cnt_q    <= '0;
          wd_q         <= '0;
          mem_sel_q    <= 1'b1;
          in_ready_q   <= 1'b1;
        end

        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.ld_wr_en   = ld_wr_en_q;
  assign bus.ld_wr_addr = ld_wr_addr_q;
  assign bus.ld_re      = ld_re_q;
  assign bus.ld_im      = ld_im_q;
  assign bus.mem_sel    = mem_sel_q;
  assign bus.fft_start  = fft_start_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_re     = out_re_q;
  assign bus.out_im     = out_im_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.drop_err   = drop_err_q;
  assign bus.tmo_err    = tmo_err_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: random frames through load / run / done,
// watchdog abort, boundary beat timing, dropped samples and mid-frame reset.
module tb_fft_frame_sched;
  localparam int BW   = 29;
  localparam int N    = 16;
  localparam int SIZE = 4;
  localparam int TMO  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fft_frame_sched_if #(.bit_width(BW), .SIZE(SIZE)) bus ();

  fft_frame_sched #(
    .bit_width(BW), .N(N), .SIZE(SIZE), .TIMEOUT(TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard state ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] ld_q[$];
  logic [63:0] out_q[$];
  logic [15:0] done_q[$];
  int frame_exp = 0;
  bit tmo_exp   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_unexpected(input string name, input logic [63:0] act);
    total_cnt++;
    $display("FAIL %s: got 0x%0h expected no event", name, act);
  endtask

  // Reference: memory address of the k-th sample in a frame.
  function automatic int model_addr(input int k);
    int rev;
    int v;
`ifdef FFT_SCHED_BITREV_EN
    rev = 0;
    v = k;
    for (int i = 0; i < SIZE; i++) begin
      rev = rev * 2 + (v % 2);
      v = v / 2;
    end
    return rev;
`else
    v = 0;
    rev = k + v;
    return rev;
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.ld_wr_en) begin
      if (ld_q.size() == 0) fail_unexpected("ld_write_unexpected", 64'({bus.ld_wr_addr, bus.ld_re, bus.ld_im}));
      else check("ld_write", 64'({bus.ld_wr_addr, bus.ld_re, bus.ld_im}), ld_q.pop_front());
    end
    if (bus.out_valid) begin
      if (out_q.size() == 0) fail_unexpected("out_beat_unexpected", 64'({bus.out_last, bus.out_re, bus.out_im}));
      else check("out_beat", 64'({bus.out_last, bus.out_re, bus.out_im}), out_q.pop_front());
    end
    if (bus.frame_done) begin
      if (done_q.size() == 0) fail_unexpected("frame_done_unexpected", 64'(bus.frame_cnt));
      else begin
        check("frame_cnt", 64'(bus.frame_cnt), 64'(done_q.pop_front()));
        check("in_ready_after_done", 64'(bus.in_ready), 64'(1));
        check("mem_sel_after_done", 64'(bus.mem_sel), 64'(1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_values();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_mem_sel", bus.mem_sel, 1);
    check("rst_ld_wr_en", bus.ld_wr_en, 0);
    check("rst_ld_wr_addr", bus.ld_wr_addr, 0);
    check("rst_ld_data", 64'({bus.ld_re, bus.ld_im}), 0);
    check("rst_fft_start", bus.fft_start, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_data", 64'({bus.out_re, bus.out_im}), 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_frame_cnt", bus.frame_cnt, 0);
    check("rst_drop_err", bus.drop_err, 0);
    check("rst_tmo_err", bus.tmo_err, 0);
    check("rst_state", bus.dbg_state, 0);
  endtask

  // Offer n samples; with n==N also verify the hand-off to the core and
  // return positioned in the first RUN cycle.
  task automatic load_frame(input int n, input bit fixed, input bit gaps, input bit noise);
    int k;
    logic [BW-1:0] re;
    logic [BW-1:0] im;
    k = 0;
    while (k < n) begin
      @(negedge clk);
      check("in_ready_load", bus.in_ready, 1);
      check("mem_sel_load", bus.mem_sel, 1);
      if (noise) begin
        bus.fft_out_en = 1'($urandom_range(0, 1));
        bus.fft_re = BW'($urandom);
        bus.fft_im = BW'($urandom);
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        if (fixed) begin
          re = BW'(k);
          im = BW'(-k);
        end else begin
          re = BW'($urandom);
          im = BW'($urandom);
        end
        bus.in_valid = 1'b1;
        bus.in_re = re;
        bus.in_im = im;
        ld_q.push_back(64'({5'(model_addr(k)), re, im}));
        k++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.fft_out_en = 1'b0;
    if (n == N) begin
      check("in_ready_after_last", bus.in_ready, 0);
      check("fft_start_early", bus.fft_start, 0);
      @(negedge clk);
      check("fft_start_pulse", bus.fft_start, 1);
      check("mem_sel_run", bus.mem_sel, 0);
      check("state_run", bus.dbg_state, 2);
    end
  endtask

  // Play the core: nbeats output beats from RUN cycle 'first', optional
  // one-cycle gaps, optional dropped sample offered at RUN cycle drop_r.
  task automatic run_core(input int first, input int nbeats, input bit gaps, input int drop_r);
    int pos[N];
    int r;
    int bi;
    int r_end;
    bit ok;
    bit en;
    logic [BW-1:0] re;
    logic [BW-1:0] im;
    r = first;
    for (int i = 0; i < nbeats; i++) begin
      pos[i] = r;
      r = r + 1 + (gaps ? int'($urandom_range(0, 1)) : 0);
    end
    ok = (nbeats == N) && (pos[N-1] <= TMO - 1);
    r_end = ok ? pos[N-1] : TMO;
    bi = 0;
    for (int rr = 0; rr <= r_end; rr++) begin
      if (rr > 0) @(negedge clk);
      if (rr == 1) check("fft_start_single", bus.fft_start, 0);
      en = 1'b0;
      if (bi < nbeats && rr <= TMO - 1 && pos[bi] == rr) begin
        en = 1'b1;
        re = BW'($urandom);
        im = BW'($urandom);
        bus.fft_re = re;
        bus.fft_im = im;
        out_q.push_back(64'({(bi == N - 1), re, im}));
        if (bi == N - 1) begin
          frame_exp++;
          done_q.push_back(16'(frame_exp));
        end
        bi++;
      end
      bus.fft_out_en = en;
      if (rr == drop_r) begin
        bus.in_valid = 1'b1;
        bus.in_re = BW'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (drop_r >= 0 && rr == drop_r + 1) check("drop_err_set", bus.drop_err, 1);
      if (!ok && rr == TMO - 1 && !tmo_exp) check("tmo_not_yet", bus.tmo_err, 0);
      if (!ok && rr == TMO) begin
        check("tmo_err_set", bus.tmo_err, 1);
        check("tmo_in_ready", bus.in_ready, 1);
        check("tmo_mem_sel", bus.mem_sel, 1);
        check("tmo_state_load", bus.dbg_state, 0);
        check("tmo_frame_cnt", bus.frame_cnt, 16'(frame_exp));
        tmo_exp = 1'b1;
      end
    end
    @(negedge clk);
    bus.fft_out_en = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- sequence ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_re = '0;
    bus.in_im = '0;
    bus.fft_out_en = 1'b0;
    bus.fft_re = '0;
    bus.fft_im = '0;

    repeat (3) @(negedge clk);
    check_reset_values();
    #2 rst_n = 1'b1;

    // Frame 1: ramp data at full rate, compact beat burst.
    load_frame(N, 1'b1, 1'b0, 1'b0);
    run_core(int'($urandom_range(0, 10)), N, 1'b0, -1);
    check("drop_err_clear", bus.drop_err, 0);

    // Frame 2: random data with gaps, core noise during load, dropped sample in RUN.
    load_frame(N, 1'b0, 1'b1, 1'b1);
    run_core(int'($urandom_range(0, 10)), N, 1'b1, 3);

    // Frame 3: final beat lands on the last watchdog cycle -> still a success.
    load_frame(N, 1'b0, 1'b0, 1'b0);
    run_core(TMO - N, N, 1'b0, -1);
    check("tmo_boundary_clear", bus.tmo_err, 0);

    // Frame 4: core stalls after N-1 beats -> watchdog abort.
    load_frame(N, 1'b0, 1'b1, 1'b0);
    run_core(int'($urandom_range(0, 10)), N - 1, 1'b1, -1);

    // Frame 5: normal frame after an abort.
    load_frame(N, 1'b0, 1'b1, 1'b0);
    run_core(int'($urandom_range(0, 10)), N, 1'b1, -1);
    check("drop_err_sticky", bus.drop_err, 1);
    check("tmo_err_sticky", bus.tmo_err, 1);

    // Reset part-way through a load; the partial frame is discarded.
    load_frame(7, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    check("ld_q_drained", ld_q.size(), 0);
    frame_exp = 0;
    tmo_exp = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Fresh frame after reset, addresses restart at the first slot.
    load_frame(N, 1'b1, 1'b0, 1'b0);
    run_core(int'($urandom_range(0, 10)), N, 1'b1, -1);

    check("ld_q_empty", ld_q.size(), 0);
    check("out_q_empty", out_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/fft_frame_sched.md
Name: fft_frame_sched

Overview:
Frame-level scheduler that sequences the in-place FFT core through three phases for each frame. First it loads N input samples into the butterfly memory. It then pulses the core's start input and waits for the core. Finally it forwards the core's N-sample output stream with frame framing.
It owns the memory write port during load and hands the port to the FFT controller otherwise. It is the single owner of frame timing between the sample source and the FFT core.

Parameters:
bit_width, 29, real/imag sample width (matches FFT datapath)
N, 16, FFT points per frame
SIZE, 4, log2(N); address ports are SIZE+1 bits, MSB always 0
TIMEOUT, 1024, max cycles allowed in RUN before abort; 16-bit watchdog

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  source sample valid
in_ready  out  1  scheduler accepts a sample this cycle
in_re  in  bit_width  source sample real
in_im  in  bit_width  source sample imag
ld_wr_en  out  1  load-phase memory write enable
ld_wr_addr  out  SIZE+1  load-phase memory write address
ld_re  out  bit_width  load-phase write data real
ld_im  out  bit_width  load-phase write data imag
mem_sel  out  1  memory write-port mux select: 1 = scheduler, 0 = FFT controller
fft_start  out  1  one-cycle start pulse to FFT controller
fft_out_en  in  1  FFT output beat valid (controller en_o & done_o)
fft_re  in  bit_width  FFT output real
fft_im  in  bit_width  FFT output imag
out_valid  out  1  output beat valid
out_last  out  1  last beat of frame
out_re  out  bit_width  output real
out_im  out  bit_width  output imag
frame_done  out  1  one-cycle pulse at frame end
frame_cnt  out  16  completed frames, wraps 0xFFFF->0
drop_err  out  1  sticky: sample offered while in_ready=0 outside LOAD
tmo_err  out  1  sticky: RUN watchdog expired

Behaviour:
- Reset (async): state=LOAD, in_ready=1, mem_sel=1, load counter=0, and out counter=0. All other outputs are 0, including data, frame_cnt and both errors. Reset mid-frame discards the frame; no fft_start is issued.
- States and transitions:
  - LOAD -> START on the N-th accepted sample.
  - START -> RUN unconditionally.
  - RUN -> DONE on the N-th output beat.
  - RUN -> LOAD on watchdog expiry.
  - DONE -> LOAD.
- LOAD:
  - in_ready=1 and mem_sel=1.
  - Accept occurs when in_valid & in_ready. The write is registered with 1-cycle latency: the next cycle drives ld_wr_en=1, ld_re/ld_im = the sample, and ld_wr_addr = f(load count).
  - The load counter increments per accept. in_ready drops in the same cycle the N-th sample is accepted, i.e. in_ready is registered and low on the following cycle.
- START:
  - in_ready=0. The last load write completes this cycle.
  - Transition to RUN sets fft_start=1 for exactly one cycle and mem_sel=0.
- RUN:
  - in_ready=0. The watchdog counts cycles from RUN entry.
  - Each fft_out_en cycle registers fft_re/fft_im to out_re/out_im with out_valid=1 on the next cycle. There is no backpressure; the output sink must always accept.
  - The out counter increments per beat. out_last=1 with the N-th beat.
  - fft_out_en in any other state is ignored.
- Watchdog: if the count reaches TIMEOUT-1 without N beats, set tmo_err, clear the counters, mem_sel=1, and return to LOAD. frame_cnt is not incremented.
- DONE: frame_done=1 for one cycle, frame_cnt+1, counters cleared, mem_sel=1, in_ready=1 on entry to LOAD.
- drop_err: set whenever in_valid=1 while in_ready=0. The sample is discarded. The flag clears only on reset.
- Simultaneous: the N-th output beat and watchdog expiry in the same cycle count as success (DONE, no tmo_err).
- Throughput: a frame occupies N load cycles (at full in_valid), plus 1 START cycle, the FFT core latency, and 1 DONE cycle.

Optional Feature:
Macro FFT_SCHED_BITREV_EN.
- Defined: ld_wr_addr = bit-reverse of the SIZE-bit load count (MSB 0), so the core receives decimation-in-time input order.
- Undefined: ld_wr_addr = load count (natural order); the source supplies pre-reordered samples.
- Only the load address changes; all other behaviour is identical.

Test Plan:
- Reset then 16 back-to-back samples re=k, im=-k (k=0..15) with BITREV_EN defined -> ld_wr_addr sequence 0,8,4,12,2,10,...,15 with matching data. in_ready low the cycle after the 16th accept. fft_start single pulse 2 cycles after the 16th accept.
- Same stimulus without BITREV_EN -> ld_wr_addr 0..15 in order. All other timing is unchanged.
- In RUN, drive fft_out_en for 16 cycles with fft_re=100+j -> out_valid 16 cycles delayed by 1. out_last only on the beat with out_re=115. frame_done pulse next cycle. frame_cnt=1. in_ready=1 again.
- Pulse in_valid during RUN -> drop_err=1 and stays 1. Memory sees no write (ld_wr_en=0). The frame completes normally.
- TIMEOUT=64, core never asserts fft_out_en -> tmo_err=1 after 64 RUN cycles. State returns to LOAD. frame_cnt unchanged.
- Assert rst_n=0 after 7 loaded samples -> all outputs at reset values immediately. After release, 16 fresh samples produce a complete frame with load addresses starting at 0.
